// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-requester result FIFOs feeding one registered ROB
// writeback port through a round-robin scheduler. rob_flush drops all
// buffered results; rst additionally clears the writeback data fields.
module wb_arbiter #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rob_flush,
    input  logic [NREQ-1:0]      in_valid,
    output logic [NREQ-1:0]      in_ready,
    input  logic [NREQ-1:0]      in_error,
    input  logic [5*NREQ-1:0]    in_ecause,
    input  logic [7*NREQ-1:0]    in_robid,
    input  logic [32*NREQ-1:0]   in_result,
    output logic                 wb_valid,
    output logic                 wb_error,
    output logic [4:0]           wb_ecause,
    output logic [6:0]           wb_robid,
    output logic [31:0]          wb_result,
    output logic [NREQ-1:0]      wb_grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic        error;
        logic [4:0]  ecause;
        logic [6:0]  robid;
        logic [31:0] result;
    } wb_entry_t;

    wb_entry_t          mem   [NREQ][DEPTH];
    logic [AW-1:0]      head  [NREQ];
    logic [AW-1:0]      tail  [NREQ];
    logic [CW-1:0]      count [NREQ];
    wb_entry_t          in_entry [NREQ];
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      rr_next;
    logic [NREQ-1:0]    push;
    logic [NREQ-1:0]    pop;
    logic [NREQ-1:0]    nonempty;
    logic [2*NREQ-1:0]  rot_wide;
    logic [PW:0]        grant_sum;
    logic               grant_any;
    logic [PW-1:0]      grant_idx;
    wb_entry_t          head_entry;

    // Advance a FIFO pointer, wrapping at DEPTH.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Per-requester handshake and unpacking of the flattened input buses.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            in_ready[i]        = (count[i] != CW'(DEPTH));
            push[i]            = in_valid[i] & in_ready[i];
            nonempty[i]        = (count[i] != '0);
            in_entry[i].error  = in_error[i];
            in_entry[i].ecause = in_ecause[5*i +: 5];
            in_entry[i].robid  = in_robid[7*i +: 7];
            in_entry[i].result = in_result[32*i +: 32];
        end
    end

    // Round-robin pick: first non-empty FIFO at or after rr_ptr.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_sum  = '0;
        pop        = '0;
        rot_wide   = {nonempty, nonempty} >> rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && rot_wide[k]) begin
                grant_any = 1'b1;
                grant_sum = {1'b0, rr_ptr} + (PW+1)'(k);
                if (grant_sum >= (PW+1)'(NREQ))
                    grant_sum = grant_sum - (PW+1)'(NREQ);
                grant_idx = grant_sum[PW-1:0];
            end
        end
        if (grant_any)
            pop[grant_idx] = 1'b1;
        rr_next    = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        head_entry = mem[grant_idx][head[grant_idx]];
    end

    // FIFO pointers and occupancy; flush and reset empty every FIFO.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst || rob_flush) begin
            for (int i = 0; i < NREQ; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (push[i])
                    tail[i] <= ptr_inc(tail[i]);
                if (pop[i])
                    head[i] <= ptr_inc(head[i]);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // FIFO storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; emptied pointers make stale data unreachable.
        for (int i = 0; i < NREQ; i++) begin
            if (push[i])
                mem[i][tail[i]] <= in_entry[i];
        end
    end

    // Round-robin pointer moves just past the granted requester.
    always_ff @(posedge clk) begin
        if (rst || rob_flush)
            rr_ptr <= '0;
        else if (grant_any)
            rr_ptr <= rr_next;
    end

    // Registered writeback bus; data fields hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_grant  <= '0;
            wb_error  <= 1'b0;
            wb_ecause <= '0;
            wb_robid  <= '0;
            wb_result <= '0;
        end else if (rob_flush) begin
            wb_valid  <= 1'b0;
            wb_grant  <= '0;
        end else if (grant_any) begin
            wb_valid  <= 1'b1;
            wb_grant  <= pop;
            wb_error  <= head_entry.error;
            wb_ecause <= head_entry.ecause;
            wb_robid  <= head_entry.robid;
            wb_result <= head_entry.result;
        end else begin
            wb_valid  <= 1'b0;
            wb_grant  <= '0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_wb_arbiter;

    localparam int NREQ  = 4;
    localparam int DEPTH = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                rob_flush;
    logic [NREQ-1:0]     in_valid;
    logic [NREQ-1:0]     in_ready;
    logic [NREQ-1:0]     in_error;
    logic [5*NREQ-1:0]   in_ecause;
    logic [7*NREQ-1:0]   in_robid;
    logic [32*NREQ-1:0]  in_result;
    logic                wb_valid;
    logic                wb_error;
    logic [4:0]          wb_ecause;
    logic [6:0]          wb_robid;
    logic [31:0]         wb_result;
    logic [NREQ-1:0]     wb_grant;

    wb_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .rob_flush (rob_flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_error  (in_error),
        .in_ecause (in_ecause),
        .in_robid  (in_robid),
        .in_result (in_result),
        .wb_valid  (wb_valid),
        .wb_error  (wb_error),
        .wb_ecause (wb_ecause),
        .wb_robid  (wb_robid),
        .wb_result (wb_result),
        .wb_grant  (wb_grant)
    );

    always #5 clk = ~clk;

    // Reference model state: one queue per requester, pointer, expected bus.
    logic [44:0]     q [NREQ][$];
    int              rr;
    logic            exp_valid;
    logic [NREQ-1:0] exp_grant;
    logic [44:0]     exp_entry;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_req(input int i, input logic e, input logic [4:0] c,
                           input logic [6:0] r, input logic [31:0] d);
        in_error[i]         = e;
        in_ecause[5*i +: 5] = c;
        in_robid[7*i +: 7]  = r;
        in_result[32*i +: 32] = d;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'($urandom_range(0, 1)), 5'($urandom), 7'($urandom), $urandom);
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        logic [NREQ-1:0] acc;
        int g;
        if (rst) begin
            for (int i = 0; i < NREQ; i++) q[i].delete();
            rr        = 0;
            exp_valid = 1'b0;
            exp_grant = '0;
            exp_entry = '0;
        end else if (rob_flush) begin
            for (int i = 0; i < NREQ; i++) q[i].delete();
            rr        = 0;
            exp_valid = 1'b0;
            exp_grant = '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                acc[i] = in_valid[i] && (q[i].size() < DEPTH);
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (rr + k) % NREQ;
                if (g < 0 && q[idx].size() > 0) g = idx;
            end
            if (g >= 0) begin
                exp_entry = q[g].pop_front();
                exp_valid = 1'b1;
                exp_grant = NREQ'(1 << g);
                rr        = (g + 1) % NREQ;
            end else begin
                exp_valid = 1'b0;
                exp_grant = '0;
            end
            for (int i = 0; i < NREQ; i++)
                if (acc[i])
                    q[i].push_back({in_error[i], in_ecause[5*i +: 5],
                                    in_robid[7*i +: 7], in_result[32*i +: 32]});
        end
    endtask

    task automatic compare_all();
        logic [NREQ-1:0] exp_ready;
        for (int i = 0; i < NREQ; i++)
            exp_ready[i] = (q[i].size() != DEPTH);
        check("in_ready",  64'(in_ready),  64'(exp_ready));
        check("wb_valid",  64'(wb_valid),  64'(exp_valid));
        check("wb_grant",  64'(wb_grant),  64'(exp_grant));
        check("wb_error",  64'(wb_error),  64'(exp_entry[44]));
        check("wb_ecause", 64'(wb_ecause), 64'(exp_entry[43:39]));
        check("wb_robid",  64'(wb_robid),  64'(exp_entry[38:32]));
        check("wb_result", 64'(wb_result), 64'(exp_entry[31:0]));
    endtask

    // Drive one cycle of inputs at the falling edge, then compare after the rising edge.
    task automatic step(input logic r, input logic f, input logic [NREQ-1:0] v);
        rst       = r;
        rob_flush = f;
        in_valid  = v;
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int run0, run2, max_run;
        logic [6:0] r1_seen [$];
        bit sent;

        rst = 1'b1; rob_flush = 1'b0; in_valid = '0;
        in_error = '0; in_ecause = '0; in_robid = '0; in_result = '0;
        @(negedge clk);

        // Reset state.
        step(1'b1, 1'b0, 4'b0000);
        check("rst_valid",  64'(wb_valid),  64'(0));
        check("rst_ready",  64'(in_ready),  64'(4'b1111));
        check("rst_result", 64'(wb_result), 64'(0));

        // Single push: write back two cycles later for exactly one cycle.
        set_req(0, 1'b0, 5'd0, 7'd5, 32'hDEADBEEF);
        step(1'b0, 1'b0, 4'b0001);
        check("single_c2_valid", 64'(wb_valid), 64'(0));
        step(1'b0, 1'b0, 4'b0000);
        check("single_c3_valid",  64'(wb_valid),  64'(1));
        check("single_c3_robid",  64'(wb_robid),  64'(5));
        check("single_c3_result", 64'(wb_result), 64'(32'hDEADBEEF));
        check("single_c3_grant",  64'(wb_grant),  64'(4'b0001));
        step(1'b0, 1'b0, 4'b0000);
        check("single_c4_valid", 64'(wb_valid), 64'(0));

        // All four push together from rr_ptr 0.
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd0, 7'(10 + i), 32'(100 + i));
        step(1'b0, 1'b0, 4'b1111);
        for (int k = 0; k < NREQ; k++) begin
            step(1'b0, 1'b0, 4'b0000);
            check("all4_robid", 64'(wb_robid), 64'(10 + k));
            check("all4_grant", 64'(wb_grant), 64'(1 << k));
        end
        step(1'b0, 1'b0, 4'b0000);
        check("all4_idle_valid", 64'(wb_valid), 64'(0));
        set_req(0, 1'b0, 5'd0, 7'd60, 32'd60);
        set_req(3, 1'b0, 5'd0, 7'd61, 32'd61);
        step(1'b0, 1'b0, 4'b1001);
        step(1'b0, 1'b0, 4'b0000);
        check("all4_rr_back_to_0", 64'(wb_grant), 64'(4'b0001));
        step(1'b0, 1'b0, 4'b0000);

        // Fairness between requesters 0 and 2.
        step(1'b1, 1'b0, 4'b0000);
        run0 = 0; run2 = 0; max_run = 0;
        for (int n = 1; n <= 16; n++) begin
            rand_data();
            step(1'b0, 1'b0, 4'b0101);
            if (n >= 2)
                check("fair_alt", 64'(wb_grant), (n % 2 == 0) ? 64'(4'b0001) : 64'(4'b0100));
            run0 = in_ready[0] ? 0 : run0 + 1;
            run2 = in_ready[2] ? 0 : run2 + 1;
            if (run0 > max_run) max_run = run0;
            if (run2 > max_run) max_run = run2;
        end
        check("fair_ready_run_le2", 64'(max_run <= 2), 64'(1));

        // Backpressure on requester 1 while the others stay busy.
        step(1'b1, 1'b0, 4'b0000);
        rand_data(); set_req(1, 1'b0, 5'd0, 7'd40, 32'd40);
        step(1'b0, 1'b0, 4'b1111);
        rand_data(); set_req(1, 1'b0, 5'd0, 7'd41, 32'd41);
        step(1'b0, 1'b0, 4'b1111);
        check("bp_ready1_low", 64'(in_ready[1]), 64'(0));
        sent = 1'b0;
        for (int c = 0; c < 30; c++) begin
            bit take;
            rand_data(); set_req(1, 1'b0, 5'd0, 7'd42, 32'd42);
            take = !sent && in_ready[1];
            step(1'b0, 1'b0, sent ? 4'b1101 : 4'b1111);
            if (take) sent = 1'b1;
            if (wb_valid && wb_grant == 4'b0010) r1_seen.push_back(wb_robid);
        end
        check("bp_third_accepted", 64'(sent), 64'(1));
        check("bp_beats", 64'(r1_seen.size()), 64'(3));
        if (r1_seen.size() == 3) begin
            check("bp_order0", 64'(r1_seen[0]), 64'(40));
            check("bp_order1", 64'(r1_seen[1]), 64'(41));
            check("bp_order2", 64'(r1_seen[2]), 64'(42));
        end

        // Flush with three results buffered and new inputs in the flush cycle.
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd0, 7'(20 + i), 32'(20 + i));
        step(1'b0, 1'b0, 4'b1111);
        step(1'b0, 1'b0, 4'b0000);
        check("flush_pre_robid", 64'(wb_robid), 64'(20));
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd0, 7'(30 + i), 32'(30 + i));
        step(1'b0, 1'b1, 4'b1111);
        check("flush_valid", 64'(wb_valid), 64'(0));
        check("flush_ready", 64'(in_ready), 64'(4'b1111));
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b0, 4'b0000);
            check("flush_quiet", 64'(wb_valid), 64'(0));
        end

        // Reset with every FIFO full.
        rand_data();
        step(1'b0, 1'b0, 4'b1111);
        rand_data();
        step(1'b0, 1'b0, 4'b1111);
        rand_data();
        step(1'b1, 1'b0, 4'b1111);
        check("rstmid_valid",  64'(wb_valid),  64'(0));
        check("rstmid_grant",  64'(wb_grant),  64'(0));
        check("rstmid_robid",  64'(wb_robid),  64'(0));
        check("rstmid_result", 64'(wb_result), 64'(0));
        check("rstmid_ready",  64'(in_ready),  64'(4'b1111));
        set_req(1, 1'b0, 5'd0, 7'd50, 32'd50);
        set_req(3, 1'b1, 5'd7, 7'd51, 32'd51);
        step(1'b0, 1'b0, 4'b1010);
        step(1'b0, 1'b0, 4'b0000);
        check("rstmid_first_grant", 64'(wb_grant), 64'(4'b0010));
        check("rstmid_first_robid", 64'(wb_robid), 64'(50));
        step(1'b0, 1'b0, 4'b0000);
        check("rstmid_err_beat", 64'({wb_error, wb_ecause}), 64'({1'b1, 5'd7}));

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 3000; c++) begin
            logic [NREQ-1:0] v;
            int dens;
            dens = (c / 250) % 3;
            v = NREQ'($urandom);
            if (dens == 0) v = v & NREQ'($urandom);
            if (dens == 2) v = v | NREQ'($urandom);
            rand_data();
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Shares the single ROB writeback port (wb_valid/wb_error/wb_ecause/wb_robid/wb_result) among NREQ execution units: ALU, branch, mul/div and LSQ load return. Each requester pushes completed results into a private 2-entry FIFO. A round-robin scheduler grants one non-empty FIFO per cycle and drives a registered writeback bus to the ROB. rob_flush discards all buffered results.

Parameters:
NREQ, 4, number of requesting execution units (2..8)
DEPTH, 2, entries per requester FIFO (power of two)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
rob_flush  input  1  ROB flush (exception/mispredict); kills all pending results
in_valid  input  NREQ  per-requester result valid
in_ready  output  NREQ  per-requester FIFO can accept
in_error  input  NREQ  per-requester exception flag
in_ecause  input  5*NREQ  exception cause, requester i at [5i+4:5i]
in_robid  input  7*NREQ  ROB index, requester i at [7i+6:7i]
in_result  input  32*NREQ  result, requester i at [32i+31:32i]
wb_valid  output  1  writeback valid to ROB
wb_error  output  1  writeback exception flag
wb_ecause  output  5  writeback cause
wb_robid  output  7  writeback ROB index
wb_result  output  32  writeback result
wb_grant  output  NREQ  one-hot source of current wb beat (tracing/perf)

Behaviour:
- Per-requester FIFO: head/tail pointers plus count (0..DEPTH); push on in_valid[i] & in_ready[i]; in_ready[i] = (count[i] != DEPTH), from registered count only; no push-through-full even when popping in the same cycle.
- Pop of FIFO i occurs in the cycle it is granted; push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
- Scheduler: rr_ptr (log2 NREQ bits), reset 0. Grant = first non-empty FIFO at index rr_ptr, rr_ptr+1, ... wrapping modulo NREQ; at most one grant per cycle. On grant g, rr_ptr <= (g+1) mod NREQ; no grant -> rr_ptr unchanged.
- Output register: granted FIFO head loads wb_error/ecause/robid/result and sets wb_valid=1, wb_grant=onehot(g); no grant -> wb_valid=0, wb_grant=0, data fields hold previous values.
- Latency: input accepted at edge t -> earliest wb_valid in cycle t+2 (empty system). Sustained throughput 1 wb/cycle whenever any FIFO is non-empty.
- Ordering: results from one requester retire in push order; no ordering guarantee across requesters.
- rob_flush (cycle t): all counts and pointers -> 0, rr_ptr -> 0, wb_valid and wb_grant -> 0 at edge t; in_valid during cycle t is dropped; grant in cycle t is discarded. in_ready all 1 from cycle t+1.
- rst: same clearing as flush; after reset wb_valid=0, wb_grant=0, wb_error=0, wb_ecause=0, wb_robid=0, wb_result=0, in_ready all 1. rst mid-traffic drops all buffered results with no partial beat.
- rst and rob_flush together: identical to rst.
- Error results are arbitrated like normal results; no priority boost.

Test Plan:
- Single push: in_valid=0001, robid0=5, result0=0xDEADBEEF at cycle 1 -> wb_valid=1, wb_robid=5, wb_result=0xDEADBEEF, wb_grant=0001 in cycle 3 only.
- All four push together (robids 10,11,12,13) with rr_ptr=0 -> wb beats in cycles 3,4,5,6 with robids 10,11,12,13; rr_ptr ends at 0.
- Fairness: requesters 0 and 2 push every accepted cycle -> wb_grant alternates 0001/0100; neither sees in_ready=0 for more than 2 consecutive cycles.
- Backpressure: requester 1 pushes 3 beats in consecutive cycles while requesters 0,2,3 are kept full -> in_ready[1]=0 after the second push; third beat accepted later; robids written back in push order.
- Flush: 3 results buffered, rob_flush pulsed in cycle 5 with in_valid=1111 -> wb_valid=0 from cycle 6, no buffered or flush-cycle result ever written back, in_ready=1111 in cycle 6.
- Reset mid-traffic: rst in cycle 4 with FIFOs full -> all wb outputs 0 and in_ready=1111 after edge; first post-reset push writes back 2 cycles later with grant from rr_ptr=0.
